// File: rtl/cmdq_pkg.sv
// Shared types for the command queue: command word, opcodes, FSM states, field slices.
// Latency: n/a (types only). Backpressure: n/a.
package cmdq_pkg;

    typedef logic [11:0] cmd_t;

    typedef enum logic [2:0] {
        OP_CAS = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERROR = 2'd3
    } cmdq_state_t;

    localparam int OPC_MSB   = 11;
    localparam int OPC_LSB   = 9;
    localparam int ADDR1_MSB = 8;
    localparam int ADDR1_LSB = 6;
    localparam int ADDR2_MSB = 5;
    localparam int ADDR2_LSB = 3;
    localparam int ADDR3_MSB = 2;
    localparam int ADDR3_LSB = 0;

endpackage

// File: rtl/cmdq_fifo.sv
// Command storage: circular buffer with wrap-bit pointers and derived occupancy.
// Latency: a push is visible in count/head the cycle after it is accepted.
// Backpressure: push_ready low only when full (independent of pop); flush beats push.
module cmdq_fifo
    import cmdq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_en,
    input  cmd_t                     push_cmd,
    input  logic                     pop,
    input  logic                     flush,
    output cmd_t                     head,
    output logic                     push_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    cmd_t        mem [DEPTH];
    logic        full;
    logic        do_push;
    logic        do_pop;

    // Same slot address with opposite wrap bits means the writer lapped the reader.
    assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign push_ready = !full;
    assign count      = wr_ptr - rd_ptr;
    assign head       = mem[rd_ptr[AW-1:0]];
    assign do_push    = push_en && !full && !flush;
    assign do_pop     = pop && (count != '0) && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_cmd;
    end

endmodule

// File: rtl/command_queue.sv
// Command queue feeding a controller: FIFO + issue FSM with WAIT timeout and sticky error. Optional CMDQ_STATS_EN adds issue/timeout counters.
// Latency: IDLE with work -> syscall next cycle; back-to-back syscalls at least 3 cycles apart.
// Backpressure: push_ready low when full; issue throttled by controller done and by ERROR until err_clr.
module command_queue
    import cmdq_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_valid,
    input  logic [11:0]              push_cmd,
    output logic                     push_ready,
    input  logic                     run,
    input  logic                     flush,
    input  logic                     err_clr,
    input  logic                     done,
    output logic [11:0]              command,
    output logic                     syscall,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     error
`ifdef CMDQ_STATS_EN
    ,
    output logic [15:0]              issued_cnt,
    output logic [7:0]               timeout_cnt
`endif
);

    localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT);

    cmdq_state_t state;
    cmdq_state_t state_nxt;
    cmd_t        head;
    logic        pop;
    logic [15:0] timer;

    cmdq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_en    (push_valid),
        .push_cmd   (push_cmd),
        .pop        (pop),
        .flush      (flush),
        .head       (head),
        .push_ready (push_ready),
        .count      (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (run && (count != '0)) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            // done takes priority over a timeout landing on the same cycle.
            ST_WAIT: begin
                if (done)                      state_nxt = ST_IDLE;
                else if (timer == TIMEOUT_VAL) state_nxt = ST_ERROR;
            end
            ST_ERROR: if (err_clr) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        syscall = 1'b0;
        busy    = 1'b0;
        error   = 1'b0;
        case (state)
            ST_ISSUE: begin syscall = 1'b1; busy = 1'b1; end
            ST_WAIT:  busy  = 1'b1;
            ST_ERROR: error = 1'b1;
            default:  ;
        endcase
    end

    assign pop = (state == ST_IDLE) && (state_nxt == ST_ISSUE);

    // command is only reloaded on a pop, so it stays stable through WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   command <= 12'h000;
        else if (pop) command <= head;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 timer <= '0;
        else if (state == ST_ISSUE) timer <= 16'd1;
        else if (state == ST_WAIT)  timer <= timer + 16'd1;
        else                        timer <= '0;
    end

`ifdef CMDQ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_cnt  <= '0;
            timeout_cnt <= '0;
        end else begin
            if (state == ST_ISSUE) issued_cnt <= issued_cnt + 16'd1;
            if (state == ST_WAIT && state_nxt == ST_ERROR && timeout_cnt != 8'hFF)
                timeout_cnt <= timeout_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_command_queue.sv
// Directed bench for command_queue: ordering, full/drop, timeout boundary, error recovery, flush, async reset.
module tb_command_queue;

    localparam int DEPTH = 8;
    localparam int TO    = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push_valid;
    logic [11:0] push_cmd;
    logic        push_ready;
    logic        run;
    logic        flush;
    logic        err_clr;
    logic        done;
    logic [11:0] command;
    logic        syscall;
    logic        busy;
    logic [3:0]  count;
    logic        error;
`ifdef CMDQ_STATS_EN
    logic [15:0] issued_cnt;
    logic [7:0]  timeout_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int n;

    command_queue #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_valid  (push_valid),
        .push_cmd    (push_cmd),
        .push_ready  (push_ready),
        .run         (run),
        .flush       (flush),
        .err_clr     (err_clr),
        .done        (done),
        .command     (command),
        .syscall     (syscall),
        .busy        (busy),
        .count       (count),
        .error       (error)
`ifdef CMDQ_STATS_EN
        ,
        .issued_cnt  (issued_cnt),
        .timeout_cnt (timeout_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [11:0] c);
        push_valid = 1'b1;
        push_cmd   = c;
        step();
        push_valid = 1'b0;
    endtask

    task automatic wait_sys(input string tag, output int cyc);
        cyc = 0;
        while (syscall !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        chk({tag, "_seen"}, syscall, 1);
    endtask

    // Waits for a syscall, checks it, returns done d cycles after the syscall cycle.
    task automatic serve(input string tag, input logic [11:0] exp, input int d, output int cyc);
        wait_sys(tag, cyc);
        chk({tag, "_cmd"}, command, exp);
        step();
        chk({tag, "_pulse"}, syscall, 0);
        for (int i = 1; i < d; i++) step();
        chk({tag, "_held"}, command, exp);
        chk({tag, "_busy"}, busy, 1);
        done = 1'b1;
        step();
        done = 1'b0;
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; push_valid = 1'b0; push_cmd = '0; run = 1'b0;
        flush = 1'b0; err_clr = 1'b0; done = 1'b0;
        #1 rst_n = 1'b0;
        step(); step();
        chk("rst_ready", push_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_cmd", command, 12'h000);
        chk("rst_sys", syscall, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", error, 0);
        rst_n = 1'b1;
        step();

        // Three commands in order, done two cycles after each syscall.
        push(12'h1C2); push(12'h050); push(12'hE4B);
        chk("q3_count", count, 3);
        chk("q3_nosys", syscall, 0);
        run = 1'b1;
        serve("o1", 12'h1C2, 2, n);
        chk("o1_lat", n, 1);
        serve("o2", 12'h050, 2, n);
        serve("o3", 12'hE4B, 2, n);
        chk("o_count", count, 0);

        // Push into an empty queue is issuable only on the following cycle.
        push(12'h3A5);
        chk("e_nosys", syscall, 0);
        chk("e_count", count, 1);
        step();
        chk("e_sys", syscall, 1);
        chk("e_cmd", command, 12'h3A5);
        chk("e_cnt0", count, 0);
        step();
        done = 1'b1; step(); done = 1'b0;

        // Push and pop on the same edge leave count unchanged; minimum spacing is 3.
        run = 1'b0;
        push(12'h111);
        run = 1'b1; push_valid = 1'b1; push_cmd = 12'h222;
        step();
        push_valid = 1'b0;
        chk("pp_count", count, 1);
        serve("pp1", 12'h111, 1, n);
        serve("pp2", 12'h222, 1, n);
        chk("pp_space", n, 1);
        run = 1'b0;

        // Fill to DEPTH, ninth push dropped, drain proves order and the drop.
        for (int i = 0; i < 8; i++) push(12'h100 + 12'(i));
        chk("f_count", count, 8);
        chk("f_ready", push_ready, 0);
        push(12'h999);
        chk("f_drop", count, 8);
        run = 1'b1;
        for (int i = 0; i < 8; i++) serve("f_drain", 12'h100 + 12'(i), 1, n);
        chk("f_empty", count, 0);
        chk("f_ready1", push_ready, 1);
        run = 1'b0;

        // done on the very last WAIT cycle (timer == TIMEOUT) still completes.
        push(12'h5A5);
        run = 1'b1;
        serve("tb", 12'h5A5, TO, n);
        chk("tb_noerr", error, 0);
        run = 1'b0;

        // CAS command times out; ERROR blocks issue and ignores done until err_clr.
        push(12'hE4B); push(12'h123);
        run = 1'b1;
        wait_sys("to", n);
        chk("to_cmd", command, 12'hE4B);
        step();
        repeat (TO - 1) step();
        chk("to_last_busy", busy, 1);
        chk("to_last_err", error, 0);
        step();
        chk("to_err", error, 1);
        chk("to_busy", busy, 0);
        done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("to_nosys", syscall, 0);
        end
        done = 1'b0;
        chk("to_sticky", error, 1);
        chk("to_keep", count, 1);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("to_clr", error, 0);
        serve("to_next", 12'h123, 2, n);
        run = 1'b0;

        // Flush during WAIT with 5 queued; a simultaneous push loses to flush.
        for (int i = 0; i < 6; i++) push(12'h600 + 12'(i));
        run = 1'b1;
        wait_sys("fl", n);
        chk("fl_cmd", command, 12'h600);
        chk("fl_cnt5", count, 5);
        step();
        flush = 1'b1; push_valid = 1'b1; push_cmd = 12'h777;
        step();
        flush = 1'b0; push_valid = 1'b0;
        chk("fl_cnt0", count, 0);
        chk("fl_busy", busy, 1);
        chk("fl_held", command, 12'h600);
        done = 1'b1; step(); done = 1'b0;
        chk("fl_idle", busy, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fl_nosys", syscall, 0);
        end
        run = 1'b0;

        // Asynchronous reset mid-WAIT abandons the in-flight command.
        push(12'h0AB); push(12'h0CD);
        run = 1'b1;
        wait_sys("ar", n);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_cmd", command, 12'h000);
        chk("ar_count", count, 0);
        chk("ar_ready", push_ready, 1);
        chk("ar_err", error, 0);
        chk("ar_sys", syscall, 0);
        step();
        rst_n = 1'b1;
        step(); step();
        chk("ar_noretry", syscall, 0);
        chk("ar_idle", busy, 0);
        run = 1'b0;

`ifdef CMDQ_STATS_EN
        for (int i = 0; i < 4; i++) push(12'h010 + 12'(i));
        push(12'hE00);
        run = 1'b1;
        for (int i = 0; i < 4; i++) serve("st", 12'h010 + 12'(i), 1, n);
        wait_sys("st_to", n);
        step();
        repeat (TO) step();
        chk("st_err", error, 1);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("st_issued", issued_cnt, 5);
        chk("st_timeout", timeout_cnt, 1);
        run = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
